// File: rtl/addpipe_pkg.sv
// Shared constants and types for the pipelined slice adder.
// The optional signed-overflow output is enabled with `define ADDPIPE_OVF_EN.
package addpipe_pkg;

   localparam int ADDPIPE_WIDTH  = 32;
   localparam int ADDPIPE_STAGES = 4;
   localparam int ADDPIPE_SLICE  = ADDPIPE_WIDTH / ADDPIPE_STAGES;

   typedef logic [ADDPIPE_WIDTH-1:0] word_t;
   typedef logic [ADDPIPE_SLICE-1:0] slice_t;

endpackage

// File: rtl/add_slice.sv
// One registered W-bit adder stage with carry in/out and a valid bit.
// Holds everything while adv is low; clears asynchronously on clr low.
module add_slice
   import addpipe_pkg::*;
#(
   parameter int W = ADDPIPE_SLICE
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         adv,
   input  logic         vi,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         ci,
   output logic [W-1:0] s,
   output logic         co,
   output logic         vo
);

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         vo <= 1'b0;
         s  <= '0;
         co <= 1'b0;
      end else if (adv) begin
         vo      <= vi;
         {co, s} <= {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
      end
   end

endmodule

// File: rtl/pipe_adder.sv
// WIDTH-bit adder split into STAGES registered slices with carry rippling between stages.
// Define ADDPIPE_OVF_EN to add the signed-overflow output ovf, aligned with out1.
module pipe_adder
   import addpipe_pkg::*;
#(
   parameter int WIDTH  = ADDPIPE_WIDTH,
   parameter int STAGES = ADDPIPE_STAGES
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out1,
`ifdef ADDPIPE_OVF_EN
   output logic             ovf,
`endif
   output logic             cout
);

   localparam int SLICE = WIDTH / STAGES;

   // Handshake: a pair is taken on an edge where in_valid && in_ready; a result
   // leaves on an edge where out_valid && out_ready. The whole pipe advances
   // together (adv) or holds together; in_ready never looks at in_valid.
   logic adv;
   logic accept;

   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;
   assign accept   = in_valid && in_ready;

   logic [STAGES-1:0]            v, c, v_in, c_in;
   logic [STAGES-1:0][SLICE-1:0] s_sl, a_sl, b_sl;

   // a_q/b_q[j]: operand bits not yet consumed, registered alongside stage j.
   // sum_q[j]: finished slices 0..j-1 packed at the top, registered alongside stage j.
   logic [WIDTH-1:0] a_q   [STAGES-1];
   logic [WIDTH-1:0] b_q   [STAGES-1];
   logic [WIDTH-1:0] sum_q [STAGES];
   logic [WIDTH-1:0] a_in  [STAGES];
   logic [WIDTH-1:0] b_in  [STAGES];
   logic [WIDTH-1:0] sum_nx[STAGES];

   always_comb begin
      a_in[0]   = in1;
      b_in[0]   = in2;
      sum_nx[0] = '0;
      for (int k = 1; k < STAGES; k++) begin
         a_in[k]   = a_q[k-1];
         b_in[k]   = b_q[k-1];
         sum_nx[k] = {s_sl[k-1], sum_q[k-1][WIDTH-1:SLICE]};
      end
      for (int k = 0; k < STAGES; k++) begin
         a_sl[k] = a_in[k][SLICE-1:0];
         b_sl[k] = b_in[k][SLICE-1:0];
      end
   end

   assign v_in = {v[STAGES-2:0], accept};
   assign c_in = {c[STAGES-2:0], cin};

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      add_slice #(.W(SLICE)) u_slice (
         .clk (clk),
         .clr (clr),
         .adv (adv),
         .vi  (v_in[k]),
         .a   (a_sl[k]),
         .b   (b_sl[k]),
         .ci  (c_in[k]),
         .s   (s_sl[k]),
         .co  (c[k]),
         .vo  (v[k])
      );
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         for (int j = 0; j < STAGES-1; j++) begin
            a_q[j] <= '0;
            b_q[j] <= '0;
         end
         for (int j = 0; j < STAGES; j++) begin
            sum_q[j] <= '0;
         end
      end else if (adv) begin
         for (int j = 0; j < STAGES-1; j++) begin
            a_q[j] <= a_in[j] >> SLICE;
            b_q[j] <= b_in[j] >> SLICE;
         end
         for (int j = 0; j < STAGES; j++) begin
            sum_q[j] <= sum_nx[j];
         end
      end
   end

   assign out1      = {s_sl[STAGES-1], sum_q[STAGES-1][WIDTH-1:SLICE]};
   assign cout      = c[STAGES-1];
   assign out_valid = v[STAGES-1];

`ifdef ADDPIPE_OVF_EN
   logic msb_a_q, msb_b_q;

   // The operand MSBs sit at the top of the last slice, so grab them as it is added.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         msb_a_q <= 1'b0;
         msb_b_q <= 1'b0;
      end else if (adv) begin
         msb_a_q <= a_in[STAGES-1][SLICE-1];
         msb_b_q <= b_in[STAGES-1][SLICE-1];
      end
   end

   assign ovf = (msb_a_q == msb_b_q) && (out1[WIDTH-1] != msb_a_q);
`endif

   logic unused_bits;
   assign unused_bits = ^{a_in[STAGES-1][WIDTH-1:SLICE], b_in[STAGES-1][WIDTH-1:SLICE],
                          sum_q[STAGES-1][SLICE-1:0]};

endmodule

// File: tb/tb_pipe_adder.sv
// Directed bench for pipe_adder: latency, carry ripple, streaming, stall, reset, mixed traffic.
// Define ADDPIPE_OVF_EN to also check the ovf output.
module tb_pipe_adder;

   localparam int W = 32;

   logic         clk;
   logic         clr;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in1;
   logic [W-1:0] in2;
   logic         cin;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out1;
   logic         cout;
`ifdef ADDPIPE_OVF_EN
   logic         ovf;
`endif

   int n_assert = 0;
   int n_fail   = 0;

   logic [W:0] exp_q[$];

   pipe_adder dut (
      .clk       (clk),
      .clr       (clr),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in1       (in1),
      .in2       (in2),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out1      (out1),
`ifdef ADDPIPE_OVF_EN
      .ovf       (ovf),
`endif
      .cout      (cout)
   );

   // clock / watchdog
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Single isolated pair; result must show up on the 4th edge after it is presented.
   task automatic send_one(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic ci, input logic [W-1:0] es, input logic ec,
                           input logic eo);
      in1 = a; in2 = b; cin = ci; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      step();
      chk({tag, "_early"}, 64'(out_valid), 64'd0);
      step();
      chk({tag, "_valid"}, 64'(out_valid), 64'd1);
      chk({tag, "_sum"}, 64'(out1), 64'(es));
      chk({tag, "_cout"}, 64'(cout), 64'(ec));
`ifdef ADDPIPE_OVF_EN
      chk({tag, "_ovf"}, 64'(ovf), 64'(eo));
`else
      if (eo) begin end
`endif
      step();
      chk({tag, "_gone"}, 64'(out_valid), 64'd0);
   endtask

   // Checks the head of the scoreboard when a result leaves, then records an accepted pair.
   task automatic sb_cycle(input string tag);
      #1;
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            chk({tag, "_unexpected"}, 64'(exp_q.size()), 64'd1);
         end else begin
            chk(tag, 64'({cout, out1}), 64'(exp_q.pop_front()));
         end
      end
      if (in_valid && in_ready) begin
         exp_q.push_back({1'b0, in1} + {1'b0, in2} + {{W{1'b0}}, cin});
      end
      step();
   endtask

   initial begin
      logic seen;
      clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      in1 = '0; in2 = '0; cin = 1'b0;

      // reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out1", 64'(out1), 64'd0);
      chk("rst_cout", 64'(cout), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      clr = 1'b1;
      step();

      // isolated vectors, hand-computed
      send_one("basic",   32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0008, 1'b0, 1'b0);
      send_one("ripple",  32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
      send_one("negneg",  32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1);
      send_one("pos_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
      send_one("mixed",   32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 32'hACF1_3569, 1'b0, 1'b0);
      send_one("slice_c", 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0);

      // back-to-back stream of (i, 0x100*i): results 0x101*i with no gaps
      for (int cyc = 0; cyc < 12; cyc++) begin
         if (cyc < 8) begin
            in1 = 32'(cyc); in2 = 32'(cyc * 32'h100); cin = 1'b0; in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         step();
         if (cyc >= 3 && cyc < 11) begin
            chk($sformatf("stream_valid_%0d", cyc - 3), 64'(out_valid), 64'd1);
            chk($sformatf("stream_sum_%0d", cyc - 3), 64'(out1), 64'((cyc - 3) * 32'h101));
         end
      end
      chk("stream_end", 64'(out_valid), 64'd0);

      // backpressure: fill 4, stall 5 cycles with input offered, then drain
      for (int j = 0; j < 4; j++) begin
         in1 = 32'h1000 + 32'(j); in2 = 32'(7 * j); cin = 1'b0; in_valid = 1'b1;
         step();
      end
      out_ready = 1'b0;
      in1 = 32'hDEAD_BEEF; in2 = 32'h1111_1111; in_valid = 1'b1;
      #1;
      chk("stall_in_ready_now", 64'(in_ready), 64'd0);
      for (int j = 0; j < 5; j++) begin
         step();
         chk($sformatf("stall_in_ready_%0d", j), 64'(in_ready), 64'd0);
         chk($sformatf("stall_valid_%0d", j), 64'(out_valid), 64'd1);
         chk($sformatf("stall_sum_%0d", j), 64'(out1), 64'h1000);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int j = 1; j < 4; j++) begin
         step();
         chk($sformatf("drain_valid_%0d", j), 64'(out_valid), 64'd1);
         chk($sformatf("drain_sum_%0d", j), 64'(out1), 64'(32'h1000 + 32'(8 * j)));
      end
      step();
      chk("drain_end", 64'(out_valid), 64'd0);

      // asynchronous reset mid-cycle with results in flight
      for (int j = 0; j < 4; j++) begin
         in1 = 32'hA0 + 32'(j); in2 = 32'h0F; cin = 1'b0; in_valid = 1'b1;
         step();
      end
      in_valid = 1'b0;
      chk("rst_mid_pre_valid", 64'(out_valid), 64'd1);
      chk("rst_mid_pre_sum", 64'(out1), 64'hAF);
      #2 clr = 1'b0;
      #1;
      chk("rst_mid_valid", 64'(out_valid), 64'd0);
      chk("rst_mid_out1", 64'(out1), 64'd0);
      chk("rst_mid_cout", 64'(cout), 64'd0);
      chk("rst_mid_in_ready", 64'(in_ready), 64'd1);
      @(posedge clk);
      #2 clr = 1'b1;
      seen = 1'b0;
      for (int j = 0; j < 6; j++) begin
         step();
         if (out_valid) seen = 1'b1;
      end
      chk("rst_no_stale", 64'(seen), 64'd0);
      send_one("post_rst", 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0);

      // mixed traffic with random backpressure against in1+in2+cin
      for (int j = 0; j < 400; j++) begin
         in_valid  = 1'($urandom_range(0, 1));
         in1       = $urandom;
         in2       = $urandom;
         cin       = 1'($urandom_range(0, 1));
         out_ready = ($urandom_range(0, 3) != 0);
         sb_cycle("rnd");
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int j = 0; j < 8; j++) begin
         sb_cycle("rnd_drain");
      end
      chk("rnd_all_drained", 64'(exp_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
